ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 170 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder: strips E0/F0 prefixes, emits key events and tracks modifiers.
// Optional 4-entry event FIFO with consumer acknowledge when PS2_DEC_FIFO_EN is defined.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       alt_held,
  output logic       err,
  output logic [1:0] state_dbg
);

  // Handshake: the upstream byte is taken once per rising edge of byte_valid; an event is
  // presented while key_valid is high and, with the FIFO, is consumed when key_ack is high
  // in the same cycle as key_valid (key_ack acts as ready).

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Encoding chosen so bit 0 means "E0 seen" and bit 1 means "F0 seen".
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_EXT     = 2'b01,
    S_BRK     = 2'b10,
    S_EXT_BRK = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bv_q;
  logic          accept;
  logic          emit, emit_ext, emit_brk;
  logic          proto_err, tmo, drop;
  logic          lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;

  assign accept    = byte_valid & ~bv_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    proto_err = 1'b0;
    tmo       = 1'b0;
    if (accept) begin
      cnt_d = '0;
      if (byte_in == 8'h00 || byte_in == 8'hFF) begin
        proto_err = 1'b1;
        state_d   = S_IDLE;
      end else if (byte_in == 8'hE0) begin
        state_d = (state_q == S_IDLE || state_q == S_EXT) ? S_EXT : S_EXT_BRK;
      end else if (byte_in == 8'hF0) begin
        state_d = (state_q == S_IDLE || state_q == S_BRK) ? S_BRK : S_EXT_BRK;
      end else begin
        emit     = 1'b1;
        emit_ext = state_q[0];
        emit_brk = state_q[1];
        state_d  = S_IDLE;
      end
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == TO_LAST) begin
      // A stalled prefix is abandoned; an accepted byte in this cycle takes priority above.
      tmo     = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bv_q     <= 1'b1;
      err      <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      lalt_q   <= 1'b0;
      ralt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bv_q    <= byte_valid;
      err     <= proto_err | tmo | drop;
      if (emit) begin
        case ({emit_ext, byte_in})
          9'h012:  lshift_q <= ~emit_brk;
          9'h059:  rshift_q <= ~emit_brk;
          9'h014:  lctrl_q  <= ~emit_brk;
          9'h114:  rctrl_q  <= ~emit_brk;
          9'h011:  lalt_q   <= ~emit_brk;
          9'h111:  ralt_q   <= ~emit_brk;
          default: ;
        endcase
      end
    end
  end

  assign shift_held = lshift_q | rshift_q;
  assign ctrl_held  = lctrl_q | rctrl_q;
  assign alt_held   = lalt_q | ralt_q;

`ifdef PS2_DEC_FIFO_EN
  logic [9:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       full, pop, push;

  assign full = (fifo_cnt == 3'd4);
  assign pop  = key_ack & key_valid;
  // A pop in the same cycle frees the slot the incoming event needs.
  assign push = emit & (~full | pop);
  assign drop = emit & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {emit_ext, emit_brk, byte_in};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  assign key_valid                     = (fifo_cnt != 3'd0);
  assign {key_ext, key_break, key_code} = fifo_mem[rd_ptr];
`else
  logic ack_unused;
  assign ack_unused = key_ack;
  assign drop       = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
    end else begin
      key_valid <= emit;
      if (emit) begin
        key_code  <= byte_in;
        key_ext   <= emit_ext;
        key_break <= emit_brk;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (short timeout for simulation).
// Define PS2_DEC_FIFO_EN for both files to exercise the FIFO build.
module tb_ps2_scancode_decoder;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       key_ack = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic       shift_held, ctrl_held, alt_held, err;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .key_ack(key_ack),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
    .shift_held(shift_held), .ctrl_held(ctrl_held), .alt_held(alt_held), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (err) err_cnt++;
`ifndef PS2_DEC_FIFO_EN
    if (key_valid) got_q.push_back({key_ext, key_break, key_code});
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    repeat (hold) @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_event(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  // Scoreboard
  task automatic check_events(input string tag);
    logic [9:0] e;
    logic [9:0] g;
    repeat (3) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'h3FF;
      check({tag, "_event"}, g, e);
    end
    got_q.delete();
  endtask

  initial begin
    int e0;
    // Reset with byte_valid held high across release: no acceptance expected
    byte_in    = 8'h1C;
    byte_valid = 1'b1;
    do_reset();
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 8'h00);
    check("rst_fields", {key_ext, key_break}, 2'b00);
    check("rst_mods", {shift_held, ctrl_held, alt_held}, 3'b000);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 2'd0);
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
`ifndef PS2_DEC_FIFO_EN
    check_events("rst_hold");

    // Plain make code, byte_valid held for 10 cycles
    send_byte(8'h1C, 10);
    expect_event(1'b0, 1'b0, 8'h1C);
    check_events("make_1c");

    // Extended break
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    expect_event(1'b1, 1'b1, 8'h75);
    check_events("ext_brk_75");
    check("ext_brk_idle", state_dbg, 2'd0);

    // Repeated E0 keeps the extended prefix
    send_byte(8'hE0, 1); send_byte(8'hE0, 1); send_byte(8'h6B, 2);
    expect_event(1'b1, 1'b0, 8'h6B);
    check_events("ext_ext_6b");

    // Shift tracking, left and right independently
    send_byte(8'h12, 1);
    expect_event(1'b0, 1'b0, 8'h12);
    check_events("lshift_make");
    check("shift_a", shift_held, 1);
    send_byte(8'h59, 1);
    check("shift_b", shift_held, 1);
    send_byte(8'hF0, 1); send_byte(8'h12, 1);
    check("shift_c", shift_held, 1);
    send_byte(8'hF0, 1); send_byte(8'h59, 1);
    check("shift_d", shift_held, 0);
    expect_event(1'b0, 1'b0, 8'h59);
    expect_event(1'b0, 1'b1, 8'h12);
    expect_event(1'b0, 1'b1, 8'h59);
    check_events("shift_seq");

    // Timeout after E0: no err one cycle early, one err at expiry, prefix discarded
    e0 = err_cnt;
    send_byte(8'hE0, 1);
    repeat (TO - 2) @(negedge clk);
    check("tmo_early", err_cnt - e0, 0);
    repeat (3) @(negedge clk);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_idle", state_dbg, 2'd0);
    send_byte(8'h1C, 1);
    expect_event(1'b0, 1'b0, 8'h1C);
    check_events("tmo_then_1c");

    // Byte accepted on the expiry cycle wins over the timeout
    e0 = err_cnt;
    send_byte(8'hE0, 1);
    repeat (TO - 2) @(negedge clk);
    byte_in    = 8'h70;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    expect_event(1'b1, 1'b0, 8'h70);
    check_events("tmo_race");
    check("tmo_race_err", err_cnt - e0, 0);

    // 0xFF after F0: error, no event, back to IDLE
    e0 = err_cnt;
    send_byte(8'hF0, 1); send_byte(8'hFF, 1);
    check_events("ff_err");
    check("ff_err_pulse", err_cnt - e0, 1);
    send_byte(8'h1C, 1);
    expect_event(1'b0, 1'b0, 8'h1C);
    check_events("ff_then_1c");

    // Reset after E0 discards the prefix
    e0 = err_cnt;
    send_byte(8'hE0, 1);
    do_reset();
    send_byte(8'h14, 1);
    expect_event(1'b0, 1'b0, 8'h14);
    check_events("rst_mid");
    check("rst_mid_ctrl", ctrl_held, 1);
    check("rst_mid_err", err_cnt - e0, 0);

    // Right ctrl/alt are tracked apart from left
    send_byte(8'hE0, 1); send_byte(8'h14, 1);
    send_byte(8'hF0, 1); send_byte(8'h14, 1);
    check("rctrl_held", ctrl_held, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h14, 1);
    check("ctrl_clear", ctrl_held, 0);
    send_byte(8'hE0, 1); send_byte(8'h11, 1);
    check("ralt_held", alt_held, 1);
    send_byte(8'h00, 1);
    send_byte(8'hF0, 1); send_byte(8'h11, 1);
    check("lalt_break_keeps_r", alt_held, 1);
    expect_event(1'b1, 1'b0, 8'h14);
    expect_event(1'b0, 1'b1, 8'h14);
    expect_event(1'b1, 1'b1, 8'h14);
    expect_event(1'b1, 1'b0, 8'h11);
    expect_event(1'b0, 1'b1, 8'h11);
    check_events("mod_seq");
`else
    // FIFO build: five codes without ack, fifth dropped with one err
    begin
      logic [7:0] codes [5];
      codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23; codes[4] = 8'h24;
      e0 = err_cnt;
      for (int i = 0; i < 5; i++) send_byte(codes[i], 1);
      repeat (2) @(negedge clk);
      check("fifo_drop_err", err_cnt - e0, 1);
      for (int i = 0; i < 4; i++) begin
        check("fifo_valid", key_valid, 1);
        check("fifo_code", key_code, codes[i]);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
      end
      check("fifo_empty", key_valid, 0);
      send_byte(8'hE0, 1); send_byte(8'h75, 1);
      check("fifo_wrap_code", key_code, 8'h75);
      check("fifo_wrap_ext", {key_valid, key_ext, key_break}, 3'b110);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
